// File: rtl/tri_mode_ethernet_mac_tx_arbiter.sv
// tri_mode_ethernet_mac_tx_arbiter
// Frame-granular round-robin arbiter that lets two transmit sources share the
// MAC transmit AXIS input. A granted source keeps the MAC until its tlast beat
// is accepted. While the PHY link is down, new frames are sunk and counted.
//
// Ports:
//   tx_mac_aclk, tx_mac_reset      clock, synchronous active-high reset
//   inband_link_status             PHY link up(1)/down(0), sampled at grant time
//   s0_axis_*, s1_axis_*           source AXIS slaves (ARP, IP/UDP)
//   tx_axis_mac_*                  AXIS master towards the MAC
//   tx_frame_cnt0/1                frames forwarded per source (wrapping)
//   tx_drop_cnt                    frames sunk while the link was down (wrapping)
//   busy                           arbiter owns a frame (not IDLE)
module tri_mode_ethernet_mac_tx_arbiter #(
  parameter int unsigned C_CNT_W     = 16,
  parameter int unsigned C_PRIO_INIT = 0
) (
  input  logic               tx_mac_aclk,
  input  logic               tx_mac_reset,
  input  logic               inband_link_status,
  input  logic [7:0]         s0_axis_tdata,
  input  logic               s0_axis_tvalid,
  input  logic               s0_axis_tlast,
  output logic               s0_axis_tready,
  input  logic [7:0]         s1_axis_tdata,
  input  logic               s1_axis_tvalid,
  input  logic               s1_axis_tlast,
  output logic               s1_axis_tready,
  output logic [7:0]         tx_axis_mac_tdata,
  output logic               tx_axis_mac_tvalid,
  output logic               tx_axis_mac_tlast,
  input  logic               tx_axis_mac_tready,
  output logic [C_CNT_W-1:0] tx_frame_cnt0,
  output logic [C_CNT_W-1:0] tx_frame_cnt1,
  output logic [C_CNT_W-1:0] tx_drop_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic L_PRIO_INIT = 1'(C_PRIO_INIT);

  state_t             r_state;
  logic               r_sel;
  logic               r_last_grant;
  logic [C_CNT_W-1:0] r_cnt0;
  logic [C_CNT_W-1:0] r_cnt1;
  logic [C_CNT_W-1:0] r_drop;

  logic       w_req;
  logic       w_pick;
  logic       w_fwd;
  logic       w_drop;
  logic [7:0] w_sel_data;
  logic       w_sel_valid;
  logic       w_sel_last;
  logic       w_sel_ready;
  logic       w_done;

  // Arbitration: on a tie the source that did not win last time goes next.
  assign w_req  = s0_axis_tvalid | s1_axis_tvalid;
  assign w_pick = (s0_axis_tvalid & s1_axis_tvalid) ? ~r_last_grant : s1_axis_tvalid;

  // Owning-source mux
  assign w_fwd       = (r_state == FWD);
  assign w_drop      = (r_state == DROP);
  assign w_sel_data  = r_sel ? s1_axis_tdata  : s0_axis_tdata;
  assign w_sel_valid = r_sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_sel_last  = r_sel ? s1_axis_tlast  : s0_axis_tlast;
  // Owner is paced by the MAC when forwarding, always accepted when sinking.
  assign w_sel_ready = w_fwd ? tx_axis_mac_tready : w_drop;
  assign w_done      = w_sel_valid & w_sel_ready & w_sel_last;

  assign tx_axis_mac_tdata  = w_fwd ? w_sel_data : 8'd0;
  assign tx_axis_mac_tvalid = w_fwd & w_sel_valid;
  assign tx_axis_mac_tlast  = w_fwd & w_sel_last;
  assign s0_axis_tready     = ~r_sel & w_sel_ready;
  assign s1_axis_tready     =  r_sel & w_sel_ready;

  assign tx_frame_cnt0 = r_cnt0;
  assign tx_frame_cnt1 = r_cnt1;
  assign tx_drop_cnt   = r_drop;
  assign busy          = (r_state != IDLE);

  // Frame FSM and counters; returning to IDLE after every frame guarantees a
  // gap cycle before the next grant.
  always_ff @(posedge tx_mac_aclk) begin
    if (tx_mac_reset) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_last_grant <= ~L_PRIO_INIT;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
      r_drop       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_sel        <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= inband_link_status ? FWD : DROP;
          end
        end
        FWD: begin
          if (w_done) begin
            r_state <= IDLE;
            if (r_sel) r_cnt1 <= r_cnt1 + C_CNT_W'(1);
            else       r_cnt0 <= r_cnt0 + C_CNT_W'(1);
          end
        end
        DROP: begin
          if (w_done) begin
            r_state <= IDLE;
            r_drop  <= r_drop + C_CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
